// File: rtl/sequential_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// digit-adjust constants, FSM state encoding and 7-segment patterns.
// Optional feature macro: SEVEN_SEG_EN (uses seg_decode below).
package sequential_bcd_pkg;

    // Width of one BCD digit and the double-dabble adjust rule (>=5 -> +3)
    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] ADJ_ADD       = 4'd3;

    // Converter FSM: IDLE waits for start, CONV shifts one bit per clock
    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Decode one BCD digit; non-decimal codes 10-15 show blank
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One-digit double-dabble correction: adds 3 (mod 16) when the digit is >= 5,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import sequential_bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Conditional add-3; 4-bit wrap is intentional and never reached in valid use
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADJ_THRESHOLD) begin
            digit_o = digit_i + ADJ_ADD;
        end
    end

endmodule

// File: rtl/sequential_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Handshake: start is sampled only in IDLE; the edge that accepts it captures
// bin and raises busy. busy drops on the edge that raises done; done is a
// one-cycle pulse marking the update of bcd/ovf, which then hold until the
// next done or reset. A start during CONV is ignored.
// Optional feature macro: SEVEN_SEG_EN adds the seg output (7 bits per digit).
module sequential_bcd_converter
    import sequential_bcd_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic                  C,
    input  logic                  R,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output state_t                state_dbg
`ifdef SEVEN_SEG_EN
    ,
    output logic [7*DIGITS-1:0]   seg
`endif
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_work_q, bcd_work_d;
    logic [WIDTH-1:0]   bin_work_q, bin_work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   adj_work;
    logic [BCD_W-1:0]   shifted_bcd;
    logic               shift_out;
    logic               last_iter;

    // Per-digit add-3 correction applied before every shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (bcd_work_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .digit_o (adj_work[BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    // Shift the adjusted digits left, pulling in the next binary MSB; the bit
    // leaving the top digit is what did not fit and feeds the overflow flag
    assign shifted_bcd = {adj_work[BCD_W-2:0], bin_work_q[WIDTH-1]};
    assign shift_out   = adj_work[BCD_W-1];
    assign last_iter   = (cnt_q == CNT_W'(1));

    // State register
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave IDLE on start, return after the last iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = CONV;
            CONV:    if (last_iter) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Datapath/output next values: load on accept, iterate in CONV, publish on last
    always_comb begin
        bcd_work_d = bcd_work_q;
        bin_work_d = bin_work_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_work_d = '0;
                    bin_work_d = bin;
                    cnt_d      = CNT_W'(WIDTH);
                    acc_d      = 1'b0;
                end
            end
            CONV: begin
                bcd_work_d = shifted_bcd;
                bin_work_d = {bin_work_q[WIDTH-2:0], 1'b0};
                cnt_d      = cnt_q - CNT_W'(1);
                acc_d      = acc_q | shift_out;
                if (last_iter) begin
                    bcd_d  = shifted_bcd;
                    ovf_d  = acc_q | shift_out;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers; reset aborts any conversion silently
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            bcd_work_q <= '0;
            bin_work_q <= '0;
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            bcd_work_q <= bcd_work_d;
            bin_work_q <= bin_work_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q == CONV);
    assign done      = done_q;
    assign bcd       = bcd_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

`ifdef SEVEN_SEG_EN
    // Display decode straight from the registered result
    for (genvar s = 0; s < DIGITS; s++) begin : g_seg
        assign seg[7*s +: 7] = seg_decode(bcd_q[BCD_DIGIT_W*s +: BCD_DIGIT_W]);
    end
`endif

endmodule

// File: tb/tb_sequential_bcd_converter.sv
// Directed testbench for sequential_bcd_converter: default instance (3 digits)
// plus a 2-digit instance sharing the same inputs to exercise overflow.
// Seven-segment checks are compiled only when SEVEN_SEG_EN is defined.
module tb_sequential_bcd_converter;
    import sequential_bcd_pkg::*;

    localparam int WIDTH = 9;

    // Clock and reset
    logic       C     = 1'b0;
    logic       R     = 1'b1;
    logic       start = 1'b0;
    logic [8:0] bin   = '0;

    always #5 C = ~C;

    logic        busy, done, ovf;
    logic [11:0] bcd;
    state_t      state_dbg;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;
    state_t      state_dbg2;
`ifdef SEVEN_SEG_EN
    logic [20:0] seg;
    logic [13:0] seg2;
`endif

    sequential_bcd_converter #(.WIDTH(WIDTH), .DIGITS(3)) u_dut (
        .C (C), .R (R), .start (start), .bin (bin),
        .busy (busy), .done (done), .bcd (bcd), .ovf (ovf),
        .state_dbg (state_dbg)
`ifdef SEVEN_SEG_EN
        , .seg (seg)
`endif
    );

    sequential_bcd_converter #(.WIDTH(WIDTH), .DIGITS(2)) u_dut2 (
        .C (C), .R (R), .start (start), .bin (bin),
        .busy (busy2), .done (done2), .bcd (bcd2), .ovf (ovf2),
        .state_dbg (state_dbg2)
`ifdef SEVEN_SEG_EN
        , .seg (seg2)
`endif
    );

    int n_checks    = 0;
    int n_fail      = 0;
    int edge_cnt    = 0;
    int done_pulses = 0;
    int busy_cycles = 0;

    // Edge counter and pre-edge sampling of done/busy (values of the ending cycle)
    always @(posedge C) begin
        edge_cnt++;
        if (done) done_pulses++;
        if (busy) busy_cycles++;
    end

    // Scoreboard compare
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver: present start/bin for one accept edge, then scramble bin
    task automatic start_conv(input logic [8:0] v, output int acc_edge);
        @(negedge C);
        bin   = v;
        start = 1'b1;
        @(posedge C);
        #1;
        acc_edge = edge_cnt;
        start    = 1'b0;
        bin      = 9'($urandom_range(0, 511));
    endtask

    // Wait (bounded) for done, sampling on the falling edge
    task automatic wait_done(input string tag, output int at_edge);
        at_edge = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge C);
            if (done) begin
                at_edge = edge_cnt;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    int acc_e, done_e, done_e1, b0, dp0;

    initial begin
        #1 bin = '0;
        // Reset state while R is held
        #19;
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_bcd",   32'(bcd), 32'h000);
        check("rst_ovf",   32'(ovf), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_busy2", 32'(busy2), 32'd0);
`ifdef SEVEN_SEG_EN
        check("rst_seg", 32'(seg), 32'({SEG_0, SEG_0, SEG_0}));
`endif
        #10 R = 1'b0;   // release at t=30, a falling edge

        // 169 -> 0x169, latency 10 edges, busy for 9 full cycles
        start_conv(9'd169, acc_e);
        b0 = busy_cycles;
        check("t1_busy_after_accept", 32'(busy), 32'd1);
        check("t1_state_conv", 32'(state_dbg), 32'(CONV));
        wait_done("t1", done_e);
        check("t1_latency", 32'(done_e - acc_e + 1), 32'd10);
        check("t1_bcd", 32'(bcd), 32'h169);
        check("t1_ovf", 32'(ovf), 32'd0);
        check("t1_busy_at_done", 32'(busy), 32'd0);
        check("t1_busy_cycles", 32'(busy_cycles - b0), 32'(WIDTH));
        check("t1_dut2_ovf", 32'(ovf2), 32'd1);
`ifdef SEVEN_SEG_EN
        check("t1_seg", 32'(seg), 32'({SEG_1, SEG_6, SEG_9}));
`endif
        @(negedge C);
        check("t1_done_one_cycle", 32'(done), 32'd0);

        // 511 then 0 back-to-back, start held in the done cycle
        start_conv(9'd511, acc_e);
        wait_done("t2a", done_e1);
        check("t2a_bcd", 32'(bcd), 32'h511);
        check("t2a_ovf", 32'(ovf), 32'd0);
        bin   = 9'd0;
        start = 1'b1;
        @(posedge C);
        #1;
        acc_e = edge_cnt;
        start = 1'b0;
        bin   = 9'd333;
        @(negedge C);
        check("t2_bcd_held", 32'(bcd), 32'h511);
        check("t2_busy_again", 32'(busy), 32'd1);
        wait_done("t2b", done_e);
        check("t2b_bcd", 32'(bcd), 32'h000);
        check("t2_done_spacing", 32'(done_e - done_e1), 32'd10);

        // 42 with an ignored start (bin=100) at conversion edge 3
        start_conv(9'd42, acc_e);
        dp0 = done_pulses;
        @(posedge C);               // edge 2
        @(negedge C);
        start = 1'b1;
        bin   = 9'd100;
        @(posedge C);               // edge 3
        #1;
        start = 1'b0;
        wait_done("t3", done_e);
        check("t3_latency", 32'(done_e - acc_e + 1), 32'd10);
        check("t3_bcd", 32'(bcd), 32'h042);
        repeat (15) @(negedge C);
        check("t3_single_done", 32'(done_pulses - dp0), 32'd1);
        check("t3_idle_busy", 32'(busy), 32'd0);
        check("t3_bcd_hold", 32'(bcd), 32'h042);

        // 300 aborted by reset before edge 4, then 7
        start_conv(9'd300, acc_e);
        repeat (2) @(posedge C);    // edges 2, 3
        @(negedge C);
        dp0 = done_pulses;
        R = 1'b1;
        #1;
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_bcd", 32'(bcd), 32'h000);
        check("t4_rst_done", 32'(done), 32'd0);
        check("t4_rst_state", 32'(state_dbg), 32'(IDLE));
        repeat (2) @(negedge C);
        R = 1'b0;
        repeat (15) @(negedge C);
        check("t4_no_done", 32'(done_pulses - dp0), 32'd0);
        start_conv(9'd7, acc_e);
        wait_done("t4b", done_e);
        check("t4b_bcd", 32'(bcd), 32'h007);

        // Two-digit instance: overflow wraps modulo 100
        start_conv(9'd169, acc_e);
        wait_done("t5a", done_e);
        check("t5a_done2", 32'(done2), 32'd1);
        check("t5a_bcd2", 32'(bcd2), 32'h69);
        check("t5a_ovf2", 32'(ovf2), 32'd1);
        check("t5a_state2", 32'(state_dbg2), 32'(IDLE));
        start_conv(9'd99, acc_e);
        wait_done("t5b", done_e);
        check("t5b_bcd2", 32'(bcd2), 32'h99);
        check("t5b_ovf2", 32'(ovf2), 32'd0);
        check("t5b_bcd", 32'(bcd), 32'h099);
`ifdef SEVEN_SEG_EN
        check("t5b_seg2", 32'(seg2), 32'({SEG_9, SEG_9}));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
